// File: rtl/fifo_umbral.sv
// Synchronous FIFO with programmable almost-full / almost-empty thresholds and a sticky error flag.
// Latency: write-to-count 1 clk; read data registered, valid_out one clock after an accepted rd_en.
// Backpressure: full drops writes (unless paired with a read), empty drops reads; either drop sets error.
module fifo_umbral #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] umbral_af,
    input  logic [ADDR_WIDTH-1:0] umbral_ae,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int                DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;

    logic wr_acc;
    logic rd_acc;
    logic overflow;
    logic underflow;

    // A write into a full FIFO is still legal when a read frees the slot in the same cycle.
    // On an empty FIFO a paired read is rejected: there is no fall-through path.
    assign rd_acc    = rd_en && !empty;
    assign wr_acc    = wr_en && (!full || rd_en);
    assign overflow  = wr_en && full && !rd_en;
    assign underflow = rd_en && empty;

    // Status flags derive straight from the registered count and the live thresholds.
    assign full         = (count == DEPTH_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= {1'b0, umbral_af});
    assign almost_empty = (count <= {1'b0, umbral_ae});

    // Storage array; not reset, and a write coinciding with reset is discarded.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers, occupancy, read data register and the sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            error     <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_acc) begin
                rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
                data_out <= mem[rd_ptr];
            end
            valid_out <= rd_acc;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + (ADDR_WIDTH + 1)'(1);
                2'b01:   count <= count - (ADDR_WIDTH + 1)'(1);
                default: count <= count;
            endcase
            if (overflow || underflow) begin
                error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_umbral.sv
module tb_fifo_umbral;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [5:0] data_in;
    logic       rd_en;
    logic [1:0] umbral_af;
    logic [1:0] umbral_ae;
    logic [5:0] data_out;
    logic       valid_out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       error;
    logic [2:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    // obs packs {full, empty, almost_full, almost_empty, error, valid_out, count}
    logic [8:0] obs;
    assign obs = {full, empty, almost_full, almost_empty, error, valid_out, count};

    fifo_umbral #(.DATA_WIDTH(6), .ADDR_WIDTH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .umbral_af    (umbral_af),
        .umbral_ae    (umbral_ae),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error        (error),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic r, input logic [5:0] d);
        wr_en   = w;
        rd_en   = r;
        data_in = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 6'h00);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        umbral_af = 2'd3;
        umbral_ae = 2'd1;
        do_reset();
        tick();
        // full=0 empty=1 af=0 ae=1 err=0 vld=0 count=0
        n_checks++;
        if (obs !== 9'b0_1_0_1_0_0_000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want %b", obs, 9'b0_1_0_1_0_0_000);
        end
        n_checks++;
        if (data_out !== 6'h00) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 00", data_out);
        end
    endtask

    task automatic test_fill_drain();
        logic [5:0] wd [4];
        logic [8:0] exp_w [4];
        logic [8:0] exp_r [4];
        wd    = '{6'h11, 6'h22, 6'h33, 6'h2A};
        exp_w = '{9'b0_0_0_1_0_0_001, 9'b0_0_0_0_0_0_010,
                  9'b0_0_1_0_0_0_011, 9'b1_0_1_0_0_0_100};
        exp_r = '{9'b0_0_1_0_0_1_011, 9'b0_0_0_0_0_1_010,
                  9'b0_0_0_1_0_1_001, 9'b0_1_0_1_0_1_000};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, wd[i]);
            tick();
            n_checks++;
            if (obs !== exp_w[i]) begin
                n_fail++;
                $display("FAIL fill_flags[%0d]: got %b want %b", i, obs, exp_w[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 6'h00);
            tick();
            n_checks++;
            if (obs !== exp_r[i] || data_out !== wd[i]) begin
                n_fail++;
                $display("FAIL drain[%0d]: got flags %b data %h want flags %b data %h",
                         i, obs, data_out, exp_r[i], wd[i]);
            end
        end
        drive(1'b0, 1'b0, 6'h00);
        tick();
        n_checks++;
        if (valid_out !== 1'b0 || data_out !== 6'h2A) begin
            n_fail++;
            $display("FAIL idle_hold: got vld %b data %h want vld 0 data 2a", valid_out, data_out);
        end
    endtask

    task automatic test_full_rw();
        logic [5:0] fill [4];
        logic [5:0] rw   [3];
        logic [5:0] tail [4];
        fill = '{6'h04, 6'h05, 6'h06, 6'h07};
        rw   = '{6'h01, 6'h02, 6'h03};
        tail = '{6'h07, 6'h01, 6'h02, 6'h03};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, fill[i]);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, rw[i]);
            tick();
            n_checks++;
            // full=1 empty=0 af=1 ae=0 err=0 vld=1 count=4
            if (obs !== 9'b1_0_1_0_0_1_100 || data_out !== fill[i]) begin
                n_fail++;
                $display("FAIL full_rw[%0d]: got flags %b data %h want flags %b data %h",
                         i, obs, data_out, 9'b1_0_1_0_0_1_100, fill[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 6'h00);
            tick();
            n_checks++;
            if (valid_out !== 1'b1 || data_out !== tail[i]) begin
                n_fail++;
                $display("FAIL wrap_drain[%0d]: got vld %b data %h want vld 1 data %h",
                         i, valid_out, data_out, tail[i]);
            end
        end
        drive(1'b0, 1'b0, 6'h00);
        tick();
    endtask

    task automatic test_overflow_underflow();
        logic [5:0] fill [4];
        fill = '{6'h08, 6'h09, 6'h0A, 6'h0B};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, fill[i]);
            tick();
        end
        drive(1'b1, 1'b0, 6'h3F);
        tick();
        n_checks++;
        if (obs !== 9'b1_0_1_0_1_0_100) begin
            n_fail++;
            $display("FAIL overflow: got %b want %b", obs, 9'b1_0_1_0_1_0_100);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 6'h00);
            tick();
            n_checks++;
            if (valid_out !== 1'b1 || data_out !== fill[i]) begin
                n_fail++;
                $display("FAIL overflow_drain[%0d]: got vld %b data %h want vld 1 data %h",
                         i, valid_out, data_out, fill[i]);
            end
        end
        // Underflow checked from a clean error flag.
        do_reset();
        drive(1'b1, 1'b0, 6'h2C);
        tick();
        drive(1'b0, 1'b1, 6'h00);
        tick();
        drive(1'b0, 1'b1, 6'h00);
        tick();
        n_checks++;
        // full=0 empty=1 af=0 ae=1 err=1 vld=0 count=0, data held at 2c
        if (obs !== 9'b0_1_0_1_1_0_000 || data_out !== 6'h2C) begin
            n_fail++;
            $display("FAIL underflow: got flags %b data %h want flags %b data 2c",
                     obs, data_out, 9'b0_1_0_1_1_0_000);
        end
        drive(1'b0, 1'b0, 6'h00);
    endtask

    task automatic test_empty_rw();
        do_reset();
        drive(1'b1, 1'b1, 6'h15);
        tick();
        n_checks++;
        // full=0 empty=0 af=0 ae=1 err=1 vld=0 count=1
        if (obs !== 9'b0_0_0_1_1_0_001) begin
            n_fail++;
            $display("FAIL empty_rw: got %b want %b", obs, 9'b0_0_0_1_1_0_001);
        end
        drive(1'b0, 1'b1, 6'h00);
        tick();
        n_checks++;
        if (valid_out !== 1'b1 || data_out !== 6'h15 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL empty_rw_read: got vld %b data %h cnt %0d want vld 1 data 15 cnt 0",
                     valid_out, data_out, count);
        end
        drive(1'b0, 1'b0, 6'h00);
    endtask

    task automatic test_thresholds();
        do_reset();
        umbral_af = 2'd0;
        umbral_ae = 2'd0;
        #1;
        n_checks++;
        if (almost_full !== 1'b1 || almost_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL thr_zero_empty: got af %b ae %b want af 1 ae 1", almost_full, almost_empty);
        end
        drive(1'b1, 1'b0, 6'h3A);
        tick();
        drive(1'b0, 1'b0, 6'h00);
        umbral_af = 2'd2;
        #1;
        n_checks++;
        if (almost_full !== 1'b0 || almost_empty !== 1'b0 || count !== 3'd1) begin
            n_fail++;
            $display("FAIL thr_one: got af %b ae %b cnt %0d want af 0 ae 0 cnt 1",
                     almost_full, almost_empty, count);
        end
        umbral_af = 2'd1;
        umbral_ae = 2'd1;
        #1;
        n_checks++;
        if (almost_full !== 1'b1 || almost_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL thr_change: got af %b ae %b want af 1 ae 1", almost_full, almost_empty);
        end
        umbral_af = 2'd3;
        umbral_ae = 2'd1;
        drive(1'b0, 1'b1, 6'h00);
        tick();
        drive(1'b0, 1'b0, 6'h00);
    endtask

    task automatic test_sticky_reset();
        // Provoke an error, then run legal traffic.
        drive(1'b0, 1'b1, 6'h00);
        tick();
        drive(1'b1, 1'b0, 6'h31);
        tick();
        drive(1'b0, 1'b1, 6'h00);
        tick();
        n_checks++;
        if (error !== 1'b1 || data_out !== 6'h31 || valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL sticky: got err %b data %h vld %b want err 1 data 31 vld 1",
                     error, data_out, valid_out);
        end
        drive(1'b1, 1'b0, 6'h10);
        tick();
        drive(1'b1, 1'b0, 6'h12);
        tick();
        drive(1'b1, 1'b0, 6'h13);
        tick();
        n_checks++;
        if (count !== 3'd3 || error !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: got cnt %0d err %b want cnt 3 err 1", count, error);
        end
        reset = 1'b1;
        drive(1'b1, 1'b0, 6'h3E);
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, 6'h00);
        n_checks++;
        // full=0 empty=1 af=0 ae=1 err=0 vld=0 count=0
        if (obs !== 9'b0_1_0_1_0_0_000) begin
            n_fail++;
            $display("FAIL mid_reset: got %b want %b", obs, 9'b0_1_0_1_0_0_000);
        end
        tick();
        n_checks++;
        if (count !== 3'd0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_write_dropped: got cnt %0d empty %b want cnt 0 empty 1", count, empty);
        end
        drive(1'b1, 1'b0, 6'h1D);
        tick();
        drive(1'b0, 1'b1, 6'h00);
        tick();
        n_checks++;
        if (data_out !== 6'h1D || valid_out !== 1'b1 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL post_reset_rd: got data %h vld %b cnt %0d want data 1d vld 1 cnt 0",
                     data_out, valid_out, count);
        end
        drive(1'b0, 1'b0, 6'h00);
    endtask

    initial begin
        reset     = 1'b1;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        data_in   = 6'h00;
        umbral_af = 2'd3;
        umbral_ae = 2'd1;
        test_reset();
        test_fill_drain();
        test_full_rw();
        test_overflow_underflow();
        test_empty_rw();
        test_thresholds();
        test_sticky_reset();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
